// File: rtl/axi_gpio_mc.sv
// Multi-channel AXI-Lite GPIO with per-bit edge interrupts, atomic SET/CLR and SLVERR decode.
// Define GPIO_DEBOUNCE_EN to insert a per-bit stable-count input filter after the synchroniser.
module axi_gpio_mc #(
  parameter int          NUM_CH          = 2,
  parameter int          WIDTH           = 32,
  parameter logic [31:0] DOUT_DEFAULT    = 32'h0,
  parameter logic [31:0] TRI_DEFAULT     = 32'hFFFF_FFFF,
  parameter int          DEBOUNCE_CYCLES = 4
) (
  input  logic                    s_axi_aclk,
  input  logic                    s_axi_aresetn,
  input  logic [8:0]              s_axi_awaddr,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [31:0]             s_axi_wdata,
  input  logic [3:0]              s_axi_wstrb,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  output logic [1:0]              s_axi_bresp,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  input  logic [8:0]              s_axi_araddr,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  output logic [31:0]             s_axi_rdata,
  output logic [1:0]              s_axi_rresp,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready,
  input  logic [NUM_CH*WIDTH-1:0] gpio_io_i,
  output logic [NUM_CH*WIDTH-1:0] gpio_io_o,
  output logic [NUM_CH*WIDTH-1:0] gpio_io_t,
  output logic                    ip2intc_irpt
);
  localparam int N = NUM_CH * WIDTH;

  typedef enum logic {W_IDLE, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  w_state_t w_state_reg, w_state_next;
  r_state_t r_state_reg, r_state_next;

  logic        aw_full_reg, w_full_reg, gier_reg;
  logic [8:0]  aw_addr_reg;
  logic [31:0] w_data_reg, rdata_reg, rd_data, wr_data, wr_mask32;
  logic [3:0]  w_strb_reg, wr_strb;
  logic [1:0]  bresp_reg, rresp_reg;
  logic [8:0]  wr_addr;
  logic        aw_hs, w_hs, b_hs, ar_hs, wr_commit, wr_ok, rd_ok;
  logic [WIDTH-1:0] wr_keep, wr_bits;
  logic [NUM_CH-1:0] irq_sum;
  logic [NUM_CH-1:0][31:0] rd_val;
  logic [N-1:0] sync1_reg, sync2_reg, prev_reg, filt;

  function automatic logic addr_ok(input logic [8:0] a);
    if (a[1:0] != 2'b00) return 1'b0;
    if (a[8]) return (a[7:0] == 8'h00) || (a[7:0] == 8'h04);
    return (32'(a[7:6]) < NUM_CH) && (a[5:2] <= 4'h8);
  endfunction

  assign s_axi_awready = !aw_full_reg && (w_state_reg == W_IDLE);
  assign s_axi_wready  = !w_full_reg && (w_state_reg == W_IDLE);
  assign s_axi_bvalid  = (w_state_reg == W_RESP);
  assign s_axi_bresp   = bresp_reg;
  assign aw_hs = s_axi_awvalid && s_axi_awready;
  assign w_hs  = s_axi_wvalid && s_axi_wready;
  assign b_hs  = s_axi_bvalid && s_axi_bready;
  // Commit on the edge where the second of AW/W arrives, using buffered or live values
  assign wr_commit = (w_state_reg == W_IDLE) && (aw_full_reg || aw_hs) && (w_full_reg || w_hs);
  assign wr_addr   = aw_full_reg ? aw_addr_reg : s_axi_awaddr;
  assign wr_data   = w_full_reg ? w_data_reg : s_axi_wdata;
  assign wr_strb   = w_full_reg ? w_strb_reg : s_axi_wstrb;
  assign wr_ok     = addr_ok(wr_addr);
  assign wr_mask32 = {{8{wr_strb[3]}}, {8{wr_strb[2]}}, {8{wr_strb[1]}}, {8{wr_strb[0]}}};
  assign wr_keep   = wr_mask32[WIDTH-1:0];
  assign wr_bits   = wr_data[WIDTH-1:0] & wr_keep;

  assign s_axi_arready = (r_state_reg == R_IDLE) && !wr_commit;
  assign s_axi_rvalid  = (r_state_reg == R_DATA);
  assign s_axi_rdata   = rdata_reg;
  assign s_axi_rresp   = rresp_reg;
  assign ar_hs = s_axi_arvalid && s_axi_arready;
  assign rd_ok = addr_ok(s_axi_araddr);

  always_comb begin
    w_state_next = w_state_reg;
    r_state_next = r_state_reg;
    case (w_state_reg)
      W_IDLE:  if (wr_commit) w_state_next = W_RESP;
      W_RESP:  if (s_axi_bready) w_state_next = W_IDLE;
      default: w_state_next = W_IDLE;
    endcase
    case (r_state_reg)
      R_IDLE:  if (ar_hs) r_state_next = R_DATA;
      R_DATA:  if (s_axi_rready) r_state_next = R_IDLE;
      default: r_state_next = R_IDLE;
    endcase
  end

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      w_state_reg <= W_IDLE;
      r_state_reg <= R_IDLE;
      aw_full_reg <= 1'b0;
      w_full_reg  <= 1'b0;
      aw_addr_reg <= '0;
      w_data_reg  <= '0;
      w_strb_reg  <= '0;
      bresp_reg   <= 2'b00;
      rresp_reg   <= 2'b00;
      rdata_reg   <= '0;
      gier_reg    <= 1'b0;
    end else begin
      w_state_reg <= w_state_next;
      r_state_reg <= r_state_next;
      if (b_hs) begin
        aw_full_reg <= 1'b0;
        w_full_reg  <= 1'b0;
      end else begin
        if (aw_hs) begin
          aw_full_reg <= 1'b1;
          aw_addr_reg <= s_axi_awaddr;
        end
        if (w_hs) begin
          w_full_reg <= 1'b1;
          w_data_reg <= s_axi_wdata;
          w_strb_reg <= s_axi_wstrb;
        end
      end
      if (wr_commit) bresp_reg <= wr_ok ? 2'b00 : 2'b10;
      if (wr_commit && wr_ok && wr_addr == 9'h100) gier_reg <= wr_data[31];
      if (ar_hs) begin
        rdata_reg <= rd_data;
        rresp_reg <= rd_ok ? 2'b00 : 2'b10;
      end
    end
  end

  always_comb begin
    rd_data = '0;
    if (s_axi_araddr[8]) begin
      if (s_axi_araddr[7:0] == 8'h00) rd_data = {gier_reg, 31'b0};
      else if (s_axi_araddr[7:0] == 8'h04) rd_data = 32'(irq_sum);
    end else begin
      for (int c = 0; c < NUM_CH; c++)
        if (s_axi_araddr[7:6] == 2'(c)) rd_data = rd_val[c];
    end
    if (!rd_ok) rd_data = '0;
  end

  assign ip2intc_irpt = gier_reg && (|irq_sum);

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
      prev_reg  <= '0;
    end else begin
      sync1_reg <= gpio_io_i;
      sync2_reg <= sync1_reg;
      prev_reg  <= filt;
    end
  end

`ifdef GPIO_DEBOUNCE_EN
  // filt follows sync only after DEBOUNCE_CYCLES consecutive disagreeing samples
  for (genvar gi = 0; gi < N; gi++) begin : g_db
    logic [7:0] cnt_reg;
    logic       filt_reg;
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
      if (!s_axi_aresetn) begin
        cnt_reg  <= '0;
        filt_reg <= 1'b0;
      end else if (sync2_reg[gi] != filt_reg) begin
        if (cnt_reg == 8'(DEBOUNCE_CYCLES - 1)) begin
          filt_reg <= sync2_reg[gi];
          cnt_reg  <= '0;
        end else begin
          cnt_reg <= cnt_reg + 8'd1;
        end
      end else begin
        cnt_reg <= '0;
      end
    end
    assign filt[gi] = filt_reg;
  end
`else
  logic [7:0] db_unused;
  assign db_unused = 8'(DEBOUNCE_CYCLES);
  assign filt = sync2_reg;
`endif

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic [WIDTH-1:0] dout_reg, tri_reg, ier_reg, isr_reg, rise_reg, fall_reg;
    logic [WIDTH-1:0] f, p, hw_set, w1c;
    logic             wr_hit;
    logic [31:0]      rd_ch;

    assign f      = filt[gi*WIDTH +: WIDTH];
    assign p      = prev_reg[gi*WIDTH +: WIDTH];
    assign hw_set = (~p & f & rise_reg) | (p & ~f & fall_reg);
    assign wr_hit = wr_commit && wr_ok && !wr_addr[8] && (wr_addr[7:6] == 2'(gi));
    assign w1c    = (wr_hit && wr_addr[5:2] == 4'h5) ? wr_bits : '0;

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
      if (!s_axi_aresetn) begin
        dout_reg <= DOUT_DEFAULT[WIDTH-1:0];
        tri_reg  <= TRI_DEFAULT[WIDTH-1:0];
        ier_reg  <= '0;
        isr_reg  <= '0;
        rise_reg <= '0;
        fall_reg <= '0;
      end else begin
        if (wr_hit) begin
          case (wr_addr[5:2])
            4'h0: dout_reg <= (dout_reg & ~wr_keep) | wr_bits;
            4'h1: tri_reg  <= (tri_reg & ~wr_keep) | wr_bits;
            4'h2: dout_reg <= dout_reg | wr_bits;
            4'h3: dout_reg <= dout_reg & ~wr_bits;
            4'h4: ier_reg  <= (ier_reg & ~wr_keep) | wr_bits;
            4'h6: rise_reg <= (rise_reg & ~wr_keep) | wr_bits;
            4'h7: fall_reg <= (fall_reg & ~wr_keep) | wr_bits;
            default: ;
          endcase
        end
        // A hardware event in the same cycle as W1C keeps the bit set
        isr_reg <= (isr_reg & ~w1c) | hw_set;
      end
    end

    always_comb begin
      rd_ch = '0;
      case (s_axi_araddr[5:2])
        4'h0: rd_ch = 32'(f);
        4'h1: rd_ch = 32'(tri_reg);
        4'h4: rd_ch = 32'(ier_reg);
        4'h5: rd_ch = 32'(isr_reg);
        4'h6: rd_ch = 32'(rise_reg);
        4'h7: rd_ch = 32'(fall_reg);
        4'h8: rd_ch = 32'(dout_reg);
        default: rd_ch = '0;
      endcase
    end

    assign rd_val[gi] = rd_ch;
    assign irq_sum[gi] = |(isr_reg & ier_reg);
    assign gpio_io_o[gi*WIDTH +: WIDTH] = dout_reg;
    assign gpio_io_t[gi*WIDTH +: WIDTH] = tri_reg;
  end
endmodule

// File: doc/axi_gpio_mc.md
# axi_gpio_mc

Multi-channel AXI-Lite GPIO controller with per-bit interrupt control. It generalises the single/dual-channel GPIO to NUM_CH channels, adding per-bit rising/falling edge selection, per-bit interrupt enable/status, atomic SET/CLR output registers, SLVERR on unmapped addresses and independent AW/W acceptance. It sits on the peripheral AXI-Lite bus, with one combined interrupt line going to the interrupt controller.

## Interface
- NUM_CH, 2, number of channels (1–4)
- WIDTH, 32, bits per channel (1–32); unimplemented bits read 0 and ignore writes
- DOUT_DEFAULT, 32'h0, reset value of every channel's DOUT
- TRI_DEFAULT, 32'hFFFF_FFFF, reset value of every channel's TRI (1 = input)
- DEBOUNCE_CYCLES, 4, stable-cycle count for the input filter (2–255, used only with the macro)
- s_axi_aclk  in  1  clock
- s_axi_aresetn  in  1  asynchronous active-low reset
- s_axi_aw{addr[8:0],valid,ready}, s_axi_w{data[31:0],strb[3:0],valid,ready}, s_axi_b{resp[1:0],valid,ready}: AXI-Lite write channels
- s_axi_ar{addr[8:0],valid,ready}, s_axi_r{data[31:0],resp[1:0],valid,ready}: AXI-Lite read channels
- gpio_io_i  in  NUM_CH*WIDTH  pad inputs, channel c at [c*WIDTH +: WIDTH]
- gpio_io_o  out  NUM_CH*WIDTH  output data
- gpio_io_t  out  NUM_CH*WIDTH  tri-state control (1 = input)
- ip2intc_irpt  out  1  combined interrupt, level-high

## Operation
- **Per-channel registers**, at base c*0x40:
  - 0x00 DATA: read returns filtered input; write updates DOUT
  - 0x04 TRI
  - 0x08 SET: write-only; DOUT |= wdata
  - 0x0C CLR: write-only; DOUT &= ~wdata
  - 0x10 IER
  - 0x14 ISR: W1C
  - 0x18 RISE_EN
  - 0x1C FALL_EN
  - 0x20 DOUT: read-only readback
- **Global registers:** 0x100 GIER (bit 31); 0x104 IRQ_SUM (RO, bit c = |(ISR_c & IER_c)).
- **Write strobes:** wstrb applies bytewise to DATA, TRI, SET, CLR, IER, RISE_EN and FALL_EN. For ISR W1C, only bytes with their strobe set take effect.
- **SLVERR:** any address that is unmapped, misaligned (addr[1:0] ≠ 0) or in a channel ≥ NUM_CH returns resp = 2'b10. The access has no side effect, and reads return 0. SET/CLR read as 0 with OKAY.
- **Input path:** two-flop synchroniser, then the optional filter, giving filt. prev is filt delayed by one clock.
  - A rise on a bit is !prev & filt; a fall is prev & !filt.
  - ISR bit sets when (rise & RISE_EN) | (fall & FALL_EN), regardless of IER.
- **Interrupt output:** ip2intc_irpt = GIER & |IRQ_SUM.
- **ISR set vs clear:** if a hardware set and a W1C hit the same bit in the same cycle, the set wins.
- **Write FSM:** states W_IDLE, W_RESP.
  - AW and W are each accepted independently whenever the corresponding buffer is empty; awready/wready = buffer empty and state = W_IDLE.
  - Once both buffers are full, the register update occurs on that clock edge and the FSM moves to W_RESP with bvalid = 1.
  - bvalid is held until bready. On the bready handshake, both buffers clear and the FSM returns to W_IDLE.
- **Read FSM:** states R_IDLE, R_DATA.
  - arready = (R_IDLE && no write commit this cycle). A write commit takes priority over a read address arriving in the same cycle.
  - On the AR handshake, rdata and rresp are registered and the FSM moves to R_DATA with rvalid = 1. These values are held stable until rready, then the FSM returns to R_IDLE.
- **Reset:** asynchronous reset at any time (mid-transaction included) returns both FSMs to idle and drops every valid; no partial write is committed.

## Timing
- Reset values:
  - awready, wready, arready = 1
  - bvalid, rvalid, bresp, rresp = 0
  - rdata = 0
  - gpio_io_o = DOUT_DEFAULT; gpio_io_t = TRI_DEFAULT
  - ip2intc_irpt = 0
  - GIER/IER/ISR/RISE_EN/FALL_EN = 0
  - synchronisers and prev = 0
- Register write effect: visible on gpio_io_o/t the cycle after the commit edge.
- Best-case write: AW+W in the same cycle, bvalid the next cycle; 2 cycles per write with bready held high.
- Read: rvalid the cycle after the AR handshake.
- Pin to DATA (no filter): the new value is readable after the 2nd rising edge following the pin change.
- Pin to ISR (no filter): ISR is set at the 3rd edge; ip2intc_irpt rises in the same cycle as ISR.
- A pin that toggles back within one synchronised sample produces no event.

## Configuration
- GPIO_DEBOUNCE_EN defined:
  - Each bit has a counter. filt takes the synchroniser output only after that output has differed from filt for DEBOUNCE_CYCLES consecutive clocks.
  - Any mismatch-free cycle resets the counter to 0.
  - This adds DEBOUNCE_CYCLES cycles of latency to the DATA and ISR paths.
- GPIO_DEBOUNCE_EN undefined: filt equals the synchroniser output, no counters are built, and DEBOUNCE_CYCLES is ignored.

## Test plan
- **Reset:** assert s_axi_aresetn low mid-write (AW accepted, W pending), then release -> gpio_io_o = DOUT_DEFAULT, bvalid = 0, and a subsequent read of 0x00 returns the pin value.
- **Decoupled write:** set ch1 DOUT to 0x0000_00F0. Write SET 0x0F with AW only, then W three cycles later -> bvalid the cycle after W, gpio_io_o[ch1] = 0x0000_00FF.
- **Atomic clear:** CLR 0xF0 -> DOUT = 0x0F. A SET with wstrb = 4'b0010 and data 0xFFFF_FFFF -> DOUT = 0x0000_FF0F.
- **Interrupt path:** on ch0, RISE_EN = 0x1, FALL_EN = 0x1, IER = 0x1, GIER = 0x8000_0000. Drive bit 0 high -> ISR = 0x1 and irq high at the 3rd edge. W1C 0x1 in the same cycle as a falling edge on bit 0 -> ISR stays 1.
- **SLVERR:** with NUM_CH = 2, read 0x080 and write 0x0C4 -> rresp/bresp = 2'b10, rdata = 0, no register change. Read 0x104 -> bit mask of pending channels.
- **Debounce (macro on, DEBOUNCE_CYCLES = 4):** pulse the pin high for 3 cycles -> no ISR. Hold it high for 6 cycles -> ISR is set exactly DEBOUNCE_CYCLES cycles later than in the macro-off run.
